// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the 16-bit pipelined core.
// Combinational lookup of the fetch PC (hit, direction, next PC) and a
// clocked update from resolved branches/jumps coming back from EX/MEM.
//
// Update interface: upd_valid is a single-cycle qualifier with no ready
// back-pressure; every cycle upd_valid=1 carries exactly one resolved
// control-transfer instruction, and the buffer always consumes it at the
// next posedge (unless reset is active, which discards it).
module branch_target_buffer #(
  parameter int PC_WIDTH   = 16,
  parameter int INDEX_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_hit,
  output logic                o_no_btb,
  output logic                o_pred_taken,
  output logic [PC_WIDTH-1:0] o_pred_pc,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_taken,
  input  logic                upd_is_jump,
  output logic [15:0]         o_miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS;

  // Entry storage; only valid_q is reset, the payload arrays are don't-care
  // until their valid bit is set.
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic                jmp_q    [ENTRIES];
  logic [15:0]         miss_count_q;
  logic [15:0]         miss_count_d;

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  upd_we;
  logic [1:0]            ctr_d;
  logic [PC_WIDTH-1:0]   target_d;
  logic                  jmp_d;

  // Lookup path: sees pre-update contents, forced to a miss during reset.
  always_comb begin
    lk_idx       = i_pc[INDEX_BITS-1:0];
    lk_tag       = i_pc[PC_WIDTH-1:INDEX_BITS];
    o_hit        = reset_n & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    o_no_btb     = reset_n & ~o_hit;
    o_pred_taken = o_hit & (jmp_q[lk_idx] | ctr_q[lk_idx][1]);
    o_pred_pc    = o_pred_taken ? target_q[lk_idx]
                                : i_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    o_miss_count = miss_count_q;
  end

  // Update path: compute the new contents of the single entry being written.
  always_comb begin
    upd_idx  = upd_pc[INDEX_BITS-1:0];
    upd_tag  = upd_pc[PC_WIDTH-1:INDEX_BITS];
    upd_hit  = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
    upd_we   = upd_valid & reset_n & (upd_hit | upd_taken);
    ctr_d    = ctr_q[upd_idx];
    target_d = target_q[upd_idx];
    jmp_d    = jmp_q[upd_idx];
    if (upd_hit) begin
      if (upd_is_jump) begin
        ctr_d = 2'd3;
      end else if (upd_taken) begin
        ctr_d = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
      end else begin
        ctr_d = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
      end
      if (upd_taken) begin
        target_d = upd_target;
        jmp_d    = upd_is_jump;
      end
    end else begin
      // Allocation on a taken miss: jumps start strongly, branches weakly taken.
      ctr_d    = upd_is_jump ? 2'd3 : 2'd2;
      target_d = upd_target;
      jmp_d    = upd_is_jump;
    end
  end

  // Saturating miss counter next state.
  always_comb begin
    miss_count_d = miss_count_q;
    if (!o_hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  // Valid bits and miss counter: synchronous reset clears everything at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q      <= '0;
      miss_count_q <= 16'd0;
    end else begin
      miss_count_q <= miss_count_d;
      if (upd_we) begin
        valid_q[upd_idx] <= 1'b1;
      end
    end
  end

  // Entry payload write (no reset; qualified by upd_we which excludes reset).
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
      jmp_q[upd_idx]    <= jmp_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed testbench for branch_target_buffer. Each step drives one cycle of
// lookup/update inputs and checks the combinational outputs against
// hand-computed values before the posedge that commits the update.
module tb_branch_target_buffer;

  logic        clk;
  logic        reset_n;
  logic [15:0] i_pc;
  logic        o_hit;
  logic        o_no_btb;
  logic        o_pred_taken;
  logic [15:0] o_pred_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;
  logic [15:0] o_miss_count;

  int n_checks;
  int n_pass;
  int step_no;
  logic [15:0] exp_miss;
  logic [18:0] exp_q[$];

  branch_target_buffer #(.PC_WIDTH(16), .INDEX_BITS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_pc         (i_pc),
    .o_hit        (o_hit),
    .o_no_btb     (o_no_btb),
    .o_pred_taken (o_pred_taken),
    .o_pred_pc    (o_pred_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_is_jump  (upd_is_jump),
    .o_miss_count (o_miss_count)
  );

  // Clock: 10 time-unit period, posedge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL step %0d %s: got %0h expected %0h", step_no, tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs, let the posedge commit.
  task automatic step(input logic rst_n, input logic [15:0] pc,
                      input logic uv, input logic [15:0] upc, input logic [15:0] utgt,
                      input logic utk, input logic ujmp,
                      input logic eh, input logic et, input logic [15:0] epc);
    logic [18:0] e;
    @(negedge clk);
    step_no++;
    reset_n     = rst_n;
    i_pc        = pc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_target  = utgt;
    upd_taken   = utk;
    upd_is_jump = ujmp;
    exp_q.push_back({eh, et, (rst_n & ~eh), epc});
    #1;
    e = exp_q.pop_front();
    check("hit",        {31'd0, o_hit},        {31'd0, e[18]});
    check("pred_taken", {31'd0, o_pred_taken}, {31'd0, e[17]});
    check("no_btb",     {31'd0, o_no_btb},     {31'd0, e[16]});
    check("pred_pc",    {16'd0, o_pred_pc},    {16'd0, e[15:0]});
    check("miss_count", {16'd0, o_miss_count}, {16'd0, exp_miss});
    if (!rst_n) exp_miss = 16'd0;
    else if (!eh && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    step_no     = 0;
    exp_miss    = 16'd0;
    reset_n     = 1'b0;
    i_pc        = 16'h0000;
    upd_valid   = 1'b0;
    upd_pc      = 16'h0000;
    upd_target  = 16'h0000;
    upd_taken   = 1'b0;
    upd_is_jump = 1'b0;
    repeat (2) @(posedge clk);

    //   rst  pc       uv  upc      utgt     tk  jmp  hit tk  pred_pc
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0011);
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0011);
    // allocate taken branch; same-cycle lookup still misses
    step(1, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0,   0, 0, 16'h0011);
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   1, 1, 16'h0040);
    // two not-taken: ctr 2->1->0
    step(1, 16'h0010, 1, 16'h0010, 16'h0000, 0, 0,   1, 1, 16'h0040);
    step(1, 16'h0010, 1, 16'h0010, 16'h0000, 0, 0,   1, 0, 16'h0011);
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   1, 0, 16'h0011);
    // four taken: ctr 0->1->2->3->3
    step(1, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0,   1, 0, 16'h0011);
    step(1, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0,   1, 0, 16'h0011);
    step(1, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0,   1, 1, 16'h0040);
    step(1, 16'h0010, 1, 16'h0010, 16'h0040, 1, 0,   1, 1, 16'h0040);
    // one not-taken: ctr 3->2, still taken
    step(1, 16'h0010, 1, 16'h0010, 16'h0000, 0, 0,   1, 1, 16'h0040);
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   1, 1, 16'h0040);
    // not-taken update to an empty entry does not allocate
    step(1, 16'h0020, 1, 16'h0020, 16'h0055, 0, 0,   0, 0, 16'h0021);
    step(1, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0021);
    // taken JMP at 0x0110 replaces the 0x0010 entry (same index)
    step(1, 16'h0010, 1, 16'h0110, 16'h0200, 1, 1,   1, 1, 16'h0040);
    step(1, 16'h0110, 0, 16'h0000, 16'h0000, 0, 0,   1, 1, 16'h0200);
    step(1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0011);
    // same-cycle lookup and allocate at 0x0030: no bypass
    step(1, 16'h0030, 1, 16'h0030, 16'h0077, 1, 0,   0, 0, 16'h0031);
    step(1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0,   1, 1, 16'h0077);
    // taken hit updates the target
    step(1, 16'h0030, 1, 16'h0030, 16'h0099, 1, 0,   1, 1, 16'h0077);
    step(1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0,   1, 1, 16'h0099);
    // PC wrap on a miss
    step(1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0000);
    // reset with a simultaneous update: outputs forced, update discarded
    step(0, 16'h0030, 1, 16'h0050, 16'h0123, 1, 0,   0, 0, 16'h0031);
    step(1, 16'h0050, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0051);
    step(1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0031);
    step(1, 16'h0110, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0111);

    // final miss counter after the last edge
    @(negedge clk);
    step_no++;
    check("miss_count_final", {16'd0, o_miss_count}, {16'd0, exp_miss});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
